// File: rtl/dac_axis_pack_fifo_if.sv
// Stream bundle between the pulse engine, the beat packer/FIFO and the RF-DAC AXI-Stream port.
// The master modport is the packer side (it masters the AXI-Stream toward the DAC);
// the slave modport is the environment side (pulse engine source plus DAC sink).
interface dac_axis_pack_fifo_if #(
    parameter int SAMP_W = 32,
    parameter int SPB    = 4
);
    logic [SAMP_W-1:0]         samp_in;
    logic                      samp_valid;
    logic                      samp_last;
    logic                      samp_ready;
    logic [SAMP_W*SPB-1:0]     M_TDATA;
    logic                      M_TVALID;
    logic                      M_TREADY;
    logic                      M_TLAST;
    logic [SAMP_W*SPB/8-1:0]   M_TKEEP;

    modport master (
        input  samp_in,
        input  samp_valid,
        input  samp_last,
        output samp_ready,
        output M_TDATA,
        output M_TVALID,
        input  M_TREADY,
        output M_TLAST,
        output M_TKEEP
    );

    modport slave (
        output samp_in,
        output samp_valid,
        output samp_last,
        input  samp_ready,
        input  M_TDATA,
        input  M_TVALID,
        output M_TREADY,
        input  M_TLAST,
        input  M_TKEEP
    );
endinterface

// File: rtl/dac_axis_pack_fifo.sv
// DAC stream master: packs SPB samples per AXI-Stream beat into a first-word-fall-through
// FIFO of DEPTH beats, marks pulse end with TLAST and partial TKEEP, and flags underrun
// when the DAC is ready but the FIFO is empty in the middle of a pulse.
// Optional feature macro: DAC_UNDERRUN_CNT_EN adds cnt_clr / underrun_cnt (16-bit saturating).
module dac_axis_pack_fifo #(
    parameter int SAMP_W = 32,
    parameter int SPB    = 4,
    parameter int DEPTH  = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    dac_axis_pack_fifo_if.master         bus,
    output logic                         underrun,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    input  logic                         cnt_clr,
    output logic [15:0]                  underrun_cnt
`endif
);

    localparam int BEAT_W = SAMP_W * SPB;
    localparam int KEEP_W = BEAT_W / 8;
    localparam int LANE_B = SAMP_W / 8;
    localparam int LANE_W = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SPB - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Packer state
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [BEAT_W-1:0] pack_q, pack_d;

    // FIFO storage and bookkeeping
    logic [BEAT_W-1:0] mem_data_q [DEPTH];
    logic [KEEP_W-1:0] mem_keep_q [DEPTH];
    logic              mem_last_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    // Control state
    state_t            state_q, state_d;
    logic              underrun_q, underrun_d;

    // Datapath / handshake helpers
    logic              samp_ready_s;
    logic              accept_s;
    logic              complete_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              head_last_s;
    logic [BEAT_W-1:0] beat_data_s;
    logic [KEEP_W-1:0] beat_keep_s;

    // Handshake decode: ready depends only on FIFO occupancy, never on M_TREADY
    always_comb begin
        empty_s      = (level_q == {LVL_W{1'b0}});
        samp_ready_s = (level_q != LVL_W'(DEPTH));
        accept_s     = bus.samp_valid & samp_ready_s;
        complete_s   = accept_s & ((lane_q == LAST_LANE) | bus.samp_last);
        push_s       = complete_s;
        pop_s        = (~empty_s) & bus.M_TREADY;
        head_last_s  = mem_last_q[rd_ptr_q];
    end

    // Assemble the beat that would be pushed now: held lanes, incoming sample, zero above
    always_comb begin
        beat_data_s = {BEAT_W{1'b0}};
        beat_keep_s = {KEEP_W{1'b0}};
        for (int k = 0; k < SPB; k++) begin
            if (LANE_W'(k) < lane_q) begin
                beat_data_s[k*SAMP_W +: SAMP_W] = pack_q[k*SAMP_W +: SAMP_W];
                beat_keep_s[k*LANE_B +: LANE_B] = {LANE_B{1'b1}};
            end else if (LANE_W'(k) == lane_q) begin
                beat_data_s[k*SAMP_W +: SAMP_W] = bus.samp_in;
                beat_keep_s[k*LANE_B +: LANE_B] = {LANE_B{1'b1}};
            end else begin
                beat_data_s[k*SAMP_W +: SAMP_W] = {SAMP_W{1'b0}};
                beat_keep_s[k*LANE_B +: LANE_B] = {LANE_B{1'b0}};
            end
        end
    end

    // Packer next state: store accepted sample in its lane, clear everything on beat completion
    always_comb begin
        lane_d = lane_q;
        pack_d = pack_q;
        if (complete_s) begin
            lane_d = {LANE_W{1'b0}};
            pack_d = {BEAT_W{1'b0}};
        end else if (accept_s) begin
            lane_d = lane_q + LANE_W'(1);
            pack_d[lane_q*SAMP_W +: SAMP_W] = bus.samp_in;
        end else begin
            lane_d = lane_q;
            pack_d = pack_q;
        end
    end

    // Packer registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lane_q <= {LANE_W{1'b0}};
            pack_q <= {BEAT_W{1'b0}};
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end

    // FIFO pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage: completed beat written on the same edge as its final sample
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= {BEAT_W{1'b0}};
                mem_keep_q[i] <= {KEEP_W{1'b0}};
                mem_last_q[i] <= 1'b0;
            end
        end else if (push_s) begin
            mem_data_q[wr_ptr_q] <= beat_data_s;
            mem_keep_q[wr_ptr_q] <= beat_keep_s;
            mem_last_q[wr_ptr_q] <= bus.samp_last;
        end
    end

    // Head of FIFO drives the stream directly; payload is forced to zero while empty
    always_comb begin
        bus.samp_ready = samp_ready_s;
        bus.M_TVALID   = ~empty_s;
        if (empty_s) begin
            bus.M_TDATA = {BEAT_W{1'b0}};
            bus.M_TKEEP = {KEEP_W{1'b0}};
            bus.M_TLAST = 1'b0;
        end else begin
            bus.M_TDATA = mem_data_q[rd_ptr_q];
            bus.M_TKEEP = mem_keep_q[rd_ptr_q];
            bus.M_TLAST = head_last_s;
        end
    end

    // Pulse tracking FSM next state and underrun detection
    always_comb begin
        state_d    = state_q;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = head_last_s ? ST_IDLE : ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
                underrun_d = 1'b0;
            end
            ST_STREAM: begin
                if (pop_s && head_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
                underrun_d = bus.M_TREADY & empty_s;
            end
            default: begin
                state_d    = ST_IDLE;
                underrun_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered underrun pulse
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
    assign level    = level_q;

`ifdef DAC_UNDERRUN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating underrun counter next state; increments on the same edge the pulse is raised
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = 16'h0000;
        end else if (underrun_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h0001;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Underrun counter register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign underrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dac_axis_pack_fifo.sv
// Self-checking bench for dac_axis_pack_fifo (SAMP_W=32, SPB=4, DEPTH=8).
// Honours DAC_UNDERRUN_CNT_EN when the design is built with it.
module tb_dac_axis_pack_fifo;

    localparam int SAMP_W = 32;
    localparam int SPB    = 4;
    localparam int DEPTH  = 8;
    localparam int LANE_B = SAMP_W / 8;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             underrun;
    logic [LVL_W-1:0] level;
`ifdef DAC_UNDERRUN_CNT_EN
    logic             cnt_clr = 1'b0;
    logic [15:0]      underrun_cnt;
`endif

    dac_axis_pack_fifo_if #(.SAMP_W(SAMP_W), .SPB(SPB)) bus ();

    dac_axis_pack_fifo #(.SAMP_W(SAMP_W), .SPB(SPB), .DEPTH(DEPTH)) dut (
        .ACLK         (clk),
        .ARESETN      (rst_n),
        .bus          (bus),
        .underrun     (underrun),
        .level        (level)
`ifdef DAC_UNDERRUN_CNT_EN
        ,
        .cnt_clr      (cnt_clr),
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queue of whole beats, list of samples of the beat being gathered
    logic [127:0] mq_data [$];
    logic [15:0]  mq_keep [$];
    logic         mq_last [$];
    logic [31:0]  pend    [$];
    bit           m_pulse;
    bit           m_under;
    int           m_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        mq_data.delete();
        mq_keep.delete();
        mq_last.delete();
        pend.delete();
        m_pulse = 1'b0;
        m_under = 1'b0;
        m_cnt   = 0;
    endfunction

    function automatic void model_close_beat(input bit last);
        logic [127:0] d;
        logic [16:0]  kk;
        d = '0;
        for (int k = 0; k < pend.size(); k++) begin
            d = d | (128'(pend[k]) << (SAMP_W * k));
        end
        kk = (17'd1 << (LANE_B * pend.size())) - 17'd1;
        mq_data.push_back(d);
        mq_keep.push_back(kk[15:0]);
        mq_last.push_back(last);
        pend.delete();
    endfunction

    task automatic check_outputs();
        bit ne;
        ne = (mq_data.size() != 0);
        chk("tvalid",     bus.M_TVALID, ne);
        chk("tdata",      bus.M_TDATA,  ne ? mq_data[0] : 128'h0);
        chk("tkeep",      bus.M_TKEEP,  ne ? mq_keep[0] : 128'h0);
        chk("tlast",      bus.M_TLAST,  ne ? mq_last[0] : 1'b0);
        chk("level",      level,        mq_data.size());
        chk("samp_ready", bus.samp_ready, mq_data.size() != DEPTH);
        chk("underrun",   underrun,     m_under);
`ifdef DAC_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt, m_cnt);
`endif
    endtask

    // Check the current cycle, advance one clock, update the model with what happened at the edge
    task automatic step();
        bit acc, pop, nxt_under;
        logic [31:0] s;
        bit lst;
        check_outputs();
        acc       = bus.samp_valid && (mq_data.size() != DEPTH);
        pop       = (mq_data.size() != 0) && bus.M_TREADY;
        nxt_under = m_pulse && bus.M_TREADY && (mq_data.size() == 0);
        s         = bus.samp_in;
        lst       = bus.samp_last;
        @(posedge clk);
        if (pop) begin
            m_pulse = !mq_last[0];
            void'(mq_data.pop_front());
            void'(mq_keep.pop_front());
            void'(mq_last.pop_front());
        end
        if (acc) begin
            pend.push_back(s);
            if ((pend.size() == SPB) || lst) model_close_beat(lst);
        end
`ifdef DAC_UNDERRUN_CNT_EN
        if (cnt_clr) m_cnt = 0;
        else if (nxt_under && (m_cnt != 65535)) m_cnt++;
`endif
        m_under = nxt_under;
        #1;
    endtask

    task automatic send(input logic [31:0] s, input bit last);
        bus.samp_in    = s;
        bus.samp_valid = 1'b1;
        bus.samp_last  = last;
        step();
    endtask

    task automatic idle(input int n);
        bus.samp_valid = 1'b0;
        bus.samp_last  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int hi;
        int n_acc;
        bus.samp_in    = '0;
        bus.samp_valid = 1'b0;
        bus.samp_last  = 1'b0;
        bus.M_TREADY   = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        idle(1);

        // 1: full beats back-to-back
        bus.M_TREADY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), 1'b0);
            if (i == 4) begin
                chk("t1_beat0", bus.M_TDATA, 128'h00000004_00000003_00000002_00000001);
                chk("t1_keep0", bus.M_TKEEP, 16'hFFFF);
                chk("t1_last0", bus.M_TLAST, 1'b0);
            end
            if (i == 8) begin
                chk("t1_beat1", bus.M_TDATA, 128'h00000008_00000007_00000006_00000005);
                chk("t1_keep1", bus.M_TKEEP, 16'hFFFF);
            end
        end

        // 2: pulse end with partial beat
        for (int i = 10; i <= 15; i++) send(32'(i), (i == 15));
        chk("t2_beat", bus.M_TDATA, {32'h0, 32'h0, 32'h0000000F, 32'h0000000E});
        chk("t2_keep", bus.M_TKEEP, 16'h00FF);
        chk("t2_last", bus.M_TLAST, 1'b1);
        idle(4);
        chk("t2_idle_no_underrun", underrun, 1'b0);

        // 3: backpressure fills the FIFO
        bus.M_TREADY = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.samp_ready === 1'b1) n_acc++;
            send(32'h100 + 32'(i), 1'b0);
        end
        chk("t3_accepted", n_acc, 32);
        chk("t3_ready_low", bus.samp_ready, 1'b0);
        chk("t3_level", level, 8);
        bus.samp_valid = 1'b0;
        bus.M_TREADY   = 1'b1;
        step();
        chk("t3_ready_after_pop", bus.samp_ready, 1'b1);
        idle(8);
        send(32'h1FF, 1'b1);
        idle(3);

        // 4: underrun during a stalled pulse
`ifdef DAC_UNDERRUN_CNT_EN
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
`endif
        for (int i = 0; i < 4; i++) send(32'h200 + 32'(i), 1'b0);
        idle(1);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (underrun === 1'b1) hi++;
        end
        chk("t4_underrun_cycles", hi, 5);
`ifdef DAC_UNDERRUN_CNT_EN
        chk("t4_cnt5", underrun_cnt, 16'd5);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("t4_cnt_clr", underrun_cnt, 16'd0);
        for (int i = 0; i < 70000; i++) step();
        chk("t4_cnt_sat", underrun_cnt, 16'hFFFF);
`endif
        send(32'h2FF, 1'b1);
        idle(3);

        // 5: reset mid-operation
        bus.M_TREADY = 1'b0;
        for (int i = 0; i < 22; i++) send(32'h300 + 32'(i), 1'b0);
        bus.samp_valid = 1'b0;
        chk("t5_level5", level, 5);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_tvalid", bus.M_TVALID, 1'b0);
        chk("t5_rst_level", level, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_ready", bus.samp_ready, 1'b1);
        chk("t5_underrun", underrun, 1'b0);
        send(32'h77, 1'b1);
        chk("t5_lane0", bus.M_TDATA, 128'h77);
        chk("t5_keep", bus.M_TKEEP, 16'h000F);
        bus.M_TREADY = 1'b1;
        idle(2);

        // 6: single-sample pulse
        bus.M_TREADY = 1'b0;
        send(32'h55, 1'b1);
        chk("t6_lane0", bus.M_TDATA, 128'h55);
        chk("t6_keep", bus.M_TKEEP, 16'h000F);
        chk("t6_last", bus.M_TLAST, 1'b1);
        bus.M_TREADY = 1'b1;
        idle(3);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.M_TREADY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                send($urandom, ($urandom_range(0, 9) == 0));
            end else begin
                idle(1);
            end
        end
        bus.M_TREADY = 1'b1;
        send($urandom, 1'b1);
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
